// File: rtl/clk_mon_pkg.sv
// Shared types and default sizing for the divided-clock ratio monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } mon_state_t;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_MAX_PERIOD = 128;
    localparam int DEF_LOCK_COUNT = 3;

endpackage

// File: rtl/clk_ratio_monitor_if.sv
// Signal bundle between a divided-clock source/checker and clk_ratio_monitor.
interface clk_ratio_monitor_if
    import clk_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    // meas_valid, mismatch and timeout are single-cycle strobes with no ready:
    // the monitor never stalls, so the consumer must sample them on the cycle
    // they are high; period/high_time are valid whenever meas_valid is high and
    // hold their value until the next strobe.
    logic             div_in;
    logic [CNT_W-1:0] exp_period;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             mismatch;
    logic             timeout;
    mon_state_t       state;

    modport master (
        output div_in, exp_period,
        input  period, high_time, meas_valid, locked, mismatch, timeout, state
    );

    modport slave (
        input  div_in, exp_period,
        output period, high_time, meas_valid, locked, mismatch, timeout, state
    );

endinterface

// File: rtl/clk_mon_rise_detect.sv
// Registers the clk-synchronous divided clock and flags its rising edge.
module clk_mon_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic div_in,
    output logic div_s,
    output logic rise
);

    logic div_d;

    // div_in comes from clk's own domain, so a single register is enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_s <= 1'b0;
            div_d <= 1'b0;
        end else begin
            div_s <= div_in;
            div_d <= div_s;
        end
    end

    assign rise = div_s & ~div_d;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures period and high time of a divided clock in clk cycles and reports
// lock, mismatch and timeout against an expected period.
module clk_ratio_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MAX_PERIOD = DEF_MAX_PERIOD,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
    input  logic                clk,
    input  logic                rst,
    clk_ratio_monitor_if.slave  mon
);

    localparam int               MC_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
    localparam logic [MC_W-1:0]  LOCK_N  = MC_W'(LOCK_COUNT);

    logic             div_s;
    logic             rise;
    mon_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [MC_W-1:0]  match_q, match_d;
    logic [MC_W-1:0]  match_inc;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             mv_q, mv_d;
    logic             mm_q, mm_d;
    logic             to_q, to_d;
    logic             good;

    clk_mon_rise_detect u_rise (
        .clk    (clk),
        .rst    (rst),
        .div_in (mon.div_in),
        .div_s  (div_s),
        .rise   (rise)
    );

    // The edge that processes a rise already sees div_s high, so both
    // counters restart at 1 and the window covers exactly one period.
    assign good      = (cnt_q == mon.exp_period) && ({hcnt_q, 1'b0} == {1'b0, cnt_q});
    assign match_inc = match_q + MC_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        match_d  = match_q;
        period_d = period_q;
        high_d   = high_q;
        mv_d     = 1'b0;
        mm_d     = 1'b0;
        to_d     = 1'b0;
        case (state_q)
            SEEK: begin
                cnt_d   = '0;
                hcnt_d  = '0;
                match_d = '0;
                if (rise) begin
                    state_d = TRACK;
                    cnt_d   = CNT_W'(1);
                    hcnt_d  = CNT_W'(1);
                end
            end
            TRACK, LOCKED: begin
                if (rise) begin
                    mv_d     = 1'b1;
                    period_d = cnt_q;
                    high_d   = hcnt_q;
                    cnt_d    = CNT_W'(1);
                    hcnt_d   = CNT_W'(1);
                    if (!good) begin
                        mm_d    = 1'b1;
                        match_d = '0;
                        state_d = TRACK;
                    end else if (state_q == TRACK) begin
                        match_d = match_inc;
                        if (match_inc >= LOCK_N) begin
                            state_d = LOCKED;
                        end
                    end
                end else if (cnt_q == MAX_CNT) begin
                    to_d    = 1'b1;
                    state_d = SEEK;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                    match_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (div_s && (hcnt_q != MAX_CNT)) begin
                        hcnt_d = hcnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = SEEK;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SEEK;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            match_q  <= '0;
            period_q <= '0;
            high_q   <= '0;
            mv_q     <= 1'b0;
            mm_q     <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            match_q  <= match_d;
            period_q <= period_d;
            high_q   <= high_d;
            mv_q     <= mv_d;
            mm_q     <= mm_d;
            to_q     <= to_d;
        end
    end

    assign mon.period     = period_q;
    assign mon.high_time  = high_q;
    assign mon.meas_valid = mv_q;
    assign mon.mismatch   = mm_q;
    assign mon.timeout    = to_q;
    assign mon.locked     = (state_q == LOCKED);
    assign mon.state      = state_q;

endmodule
